// File: rtl/seq_restoring_divider.sv
`timescale 1ns/1ps
// seq_restoring_divider: unsigned restoring divider,
// one shift/trial-subtract step per clock on a shared subtractor.
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  // r_q MSB is always 0 here (R < 2^(step)), so the wide
  // shift equals {0, R<<1 | Q msb}.
  logic [WIDTH:0]   r_wide;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;

  // One restoring step: shift, trial subtract, keep or restore.
  always_comb begin
    r_wide = {r_q, q_q[WIDTH-1]};
    trial  = r_wide - {1'b0, d_q};
    r_step = trial[WIDTH] ? r_wide[WIDTH-1:0]
                          : trial[WIDTH-1:0];
    q_step = {q_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          d_d   = divisor;
          q_d   = dividend;
          r_d   = '0;
          cnt_d = '0;
          if (divisor == '0) begin
            state_d = S_DONE;
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        q_d   = q_step;
        r_d   = r_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          quo_d   = q_step;
          rem_d   = r_step;
          dbz_d   = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
`timescale 1ns/1ps
// tb_seq_restoring_divider: directed and random checks
// against a plain-arithmetic reference model.
module tb_seq_restoring_divider;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int checks;
  int failures;

  seq_restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
    check_eq({tag, "_quo"}, 32'(quotient), 0);
    check_eq({tag, "_rem"}, 32'(remainder), 0);
    check_eq({tag, "_dbz"}, 32'(div_by_zero), 0);
  endtask

  // Launch one division, wait for done, compare with the model.
  task automatic run_div(input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
    int n;
    int eq;
    int er;
    eq = (b == 0) ? (2**WIDTH - 1) : int'(a) / int'(b);
    er = (b == 0) ? int'(a) : int'(a) % int'(b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    check_eq("busy_after_start", 32'(busy), 1);
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check_eq("latency", n, (b == 0) ? 1 : WIDTH + 1);
    check_eq("quo", 32'(quotient), eq);
    check_eq("rem", 32'(remainder), er);
    check_eq("dbz", 32'(div_by_zero), (b == 0) ? 1 : 0);
    if (b != 0) begin
      check_eq("invariant",
               int'(quotient) * int'(b) + int'(remainder),
               int'(a));
      check_eq("rem_lt_div", 32'(remainder < b), 1);
    end
    tick();
    check_eq("done_pulse", 32'(done), 0);
    check_eq("idle", 32'(busy), 0);
  endtask

  initial begin
    int nd;
    int n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] got_q;
    logic [WIDTH-1:0] got_r;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    run_div(8'd100, 8'd7);
    run_div(8'd255, 8'd1);
    run_div(8'd255, 8'd255);
    run_div(8'd5, 8'd9);
    run_div(8'd0, 8'd3);
    run_div(8'd200, 8'd128);
    run_div(8'd200, 8'd0);
    run_div(8'd9, 8'd2);

    // start and operand changes during RUN are ignored
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    start    = 1'b1;
    dividend = 8'd99;
    divisor  = 8'd3;
    tick();
    start    = 1'b0;
    dividend = 8'd1;
    divisor  = 8'd0;
    nd = 0;
    got_q = '0;
    got_r = '0;
    for (int i = 0; i < 15; i++) begin
      if (done) begin
        nd++;
        got_q = quotient;
        got_r = remainder;
      end
      tick();
    end
    check_eq("ign_done_cnt", nd, 1);
    check_eq("ign_quo", 32'(got_q), 10);
    check_eq("ign_rem", 32'(got_r), 0);

    // start held through DONE: taken in the following IDLE
    dividend = 8'd12;
    divisor  = 8'd4;
    start    = 1'b1;
    tick();
    n = 1;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check_eq("held_first_done", 32'(done), 1);
    tick();
    check_eq("held_idle_busy", 32'(busy), 0);
    check_eq("held_idle_done", 32'(done), 0);
    tick();
    check_eq("held_accept", 32'(busy), 1);
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check_eq("held_latency", n, WIDTH + 1);
    check_eq("held_quo", 32'(quotient), 3);
    tick();

    // reset abort mid-RUN
    run_div(8'd50, 8'd5);
    dividend = 8'd77;
    divisor  = 8'd6;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    tick();
    tick();
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) nd++;
      tick();
    end
    check_eq("abort_no_done", nd, 0);
    run_div(8'd77, 8'd6);

    // random back-to-back divisions
    for (int i = 0; i < 3000; i++) begin
      a = WIDTH'($urandom_range(2**WIDTH - 1));
      b = WIDTH'($urandom_range(2**WIDTH - 1, 1));
      run_div(a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
